// File: rtl/serial_borrow_subtractor_if.sv
// Handshake and operand/result bundle for serial_borrow_subtractor.
// OVF is present only when SERIAL_BORROW_SUBTRACTOR_OVF_EN is defined.
interface serial_borrow_subtractor_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Y;
  logic             Bout;
  logic             busy;
  logic             done;
`ifdef SERIAL_BORROW_SUBTRACTOR_OVF_EN
  logic             OVF;

  modport master (output start, A, B, input Y, Bout, busy, done, OVF);
  modport slave  (input start, A, B, output Y, Bout, busy, done, OVF);
`else
  modport master (output start, A, B, input Y, Bout, busy, done);
  modport slave  (input start, A, B, output Y, Bout, busy, done);
`endif
endinterface

// File: rtl/serial_borrow_subtractor.sv
// Bit-serial Y = A - B, LSB first, one borrow flop, start/busy/done handshake.
// Optional signed-overflow output enabled by SERIAL_BORROW_SUBTRACTOR_OVF_EN.
module serial_borrow_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input logic                     clk,
  input logic                     rst,
  serial_borrow_subtractor_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              bor_q, bor_d;
  logic              bout_q, bout_d;
  logic              a_bit, b_bit, diff, bor_next;
`ifdef SERIAL_BORROW_SUBTRACTOR_OVF_EN
  logic              a_msb_q, a_msb_d;
  logic              b_msb_q, b_msb_d;
  logic              ovf_q, ovf_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      bor_q   <= 1'b0;
      bout_q  <= 1'b0;
`ifdef SERIAL_BORROW_SUBTRACTOR_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      bor_q   <= bor_d;
      bout_q  <= bout_d;
`ifdef SERIAL_BORROW_SUBTRACTOR_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  // One full-subtractor cell evaluated on the current LSBs.
  assign a_bit    = a_q[0];
  assign b_bit    = b_q[0];
  assign diff     = a_bit ^ b_bit ^ bor_q;
  assign bor_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bor_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    bor_d   = bor_q;
    bout_d  = bout_q;
`ifdef SERIAL_BORROW_SUBTRACTOR_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif

    unique case (state_q)
      StIdle, StDone: begin
        // DONE accepts start exactly like IDLE so operations can run back-to-back.
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          bor_d   = 1'b0;
          cnt_d   = '0;
          state_d = StShift;
`ifdef SERIAL_BORROW_SUBTRACTOR_OVF_EN
          a_msb_d = bus.A[WIDTH-1];
          b_msb_d = bus.B[WIDTH-1];
`endif
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {diff, res_q[WIDTH-1:1]};
        bor_d = bor_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StDone;
          y_d     = res_d;
          bout_d  = bor_next;
`ifdef SERIAL_BORROW_SUBTRACTOR_OVF_EN
          // The last difference bit is the result MSB.
          ovf_d   = (a_msb_q ^ b_msb_q) & (a_msb_q ^ diff);
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.Y    = y_q;
  assign bus.Bout = bout_q;
  assign bus.busy = (state_q == StShift);
  assign bus.done = (state_q == StDone);
`ifdef SERIAL_BORROW_SUBTRACTOR_OVF_EN
  assign bus.OVF  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Self-checking bench for serial_borrow_subtractor: directed cases plus random
// operations checked against an arithmetic reference model.
module tb_serial_borrow_subtractor;

  localparam int unsigned W = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  logic [W-1:0] y_hold;
  logic         bout_hold;
  logic         ovf_hold;

  serial_borrow_subtractor_if #(.WIDTH(W)) bus ();

  serial_borrow_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    else n_pass++;
  endtask

  // Reference: plain unsigned/signed arithmetic on the operands.
  function automatic logic [W-1:0] ref_y(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned m;
    m = (int'(a) - int'(b) + (1 << W)) % (1 << W);
    return W'(m);
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb, d;
    sa = (int'(a) >= (1 << (W - 1))) ? int'(a) - (1 << W) : int'(a);
    sb = (int'(b) >= (1 << (W - 1))) ? int'(b) - (1 << W) : int'(b);
    d  = sa - sb;
    return (d < -(1 << (W - 1))) || (d > (1 << (W - 1)) - 1);
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".y"}, 32'(bus.Y), 32'(y_hold));
    check({tag, ".bout"}, 32'(bus.Bout), 32'(bout_hold));
`ifdef SERIAL_BORROW_SUBTRACTOR_OVF_EN
    check({tag, ".ovf"}, 32'(bus.OVF), 32'(ovf_hold));
`endif
  endtask

  // Called at a negedge; start is sampled on the next posedge. Returns at the
  // negedge of the done cycle, so a following call runs back-to-back.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int i = 0; i < int'(W); i++) begin
      @(negedge clk);
      check("busy_shift", 32'(bus.busy), 32'd1);
      check("done_shift", 32'(bus.done), 32'd0);
      check_outputs("hold_shift");
      if (noise) begin
        bus.start = 1'($urandom);
        bus.A     = W'($urandom);
        bus.B     = W'($urandom);
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    y_hold    = ref_y(a, b);
    bout_hold = (a < b);
    ovf_hold  = ref_ovf(a, b);
    check("done_pulse", 32'(bus.done), 32'd1);
    check("busy_done", 32'(bus.busy), 32'd0);
    check_outputs("result");
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    check("done_idle", 32'(bus.done), 32'd0);
    check("busy_idle", 32'(bus.busy), 32'd0);
    check_outputs("hold_idle");
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    y_hold    = '0;
    bout_hold = 1'b0;
    ovf_hold  = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check_outputs("rst");
    idle_cycle();

    run_op(4'b0111, 4'b0010, 1'b0);
    idle_cycle();
    run_op(4'b0010, 4'b0111, 1'b0);
    idle_cycle();
    run_op(4'b0000, 4'b0001, 1'b0);
    idle_cycle();
    run_op(4'b1111, 4'b1111, 1'b0);
    idle_cycle();
    // Start pulses and operand changes during SHIFT must be ignored.
    run_op(4'b1100, 4'b0001, 1'b1);
    run_op(4'b1001, 4'b0111, 1'b0);
    idle_cycle();

    // Reset in the middle of SHIFT discards the operation.
    bus.start = 1'b1;
    bus.A     = 4'b1010;
    bus.B     = 4'b0011;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    y_hold    = '0;
    bout_hold = 1'b0;
    ovf_hold  = 1'b0;
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_done", 32'(bus.done), 32'd0);
    check_outputs("rst_mid");
    repeat (W + 1) idle_cycle();
    run_op(4'b1010, 4'b0011, 1'b0);
    idle_cycle();

    run_op(4'b1000, 4'b0001, 1'b0);
    run_op(4'b0111, 4'b1111, 1'b0);
    run_op(4'b0101, 4'b0011, 1'b0);
    run_op(4'b0110, 4'b0000, 1'b0);
    idle_cycle();

    for (int k = 0; k < 60; k++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) idle_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_borrow_subtractor.md
Name: serial_borrow_subtractor

Overview:
- Bit-serial sequential subtractor computing Y = A - B, one bit per clock, LSB first, with a single borrow flip-flop.
- Inverse-direction companion to the team's combinational carry-ripple adder. Its results are directly comparable against adder outputs: A - B + B == A mod 2^WIDTH.
- Sits behind a start/busy/done handshake for use by multi-cycle datapaths and self-checking benches.

Parameters:
- WIDTH, 4, operand and result width in bits (must be >= 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when the block is not busy
- A  input  WIDTH  minuend; captured on the accepted start
- B  input  WIDTH  subtrahend; captured on the accepted start
- Y  output  WIDTH  difference A - B mod 2^WIDTH; registered and held between operations
- Bout  output  1  final borrow out; 1 when A < B unsigned
- busy  output  1  high while bits are being processed
- done  output  1  single-cycle pulse when Y/Bout update

Behaviour:
- States:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1.
  - DONE: busy=0, done=1, held for one cycle.
- Reset (rst=1 at a clock edge):
  - state <= IDLE, Y <= 0, Bout <= 0, busy <= 0, done <= 0.
  - Bit counter, borrow and internal shift registers cleared.
  - Reset has priority over everything, including mid-SHIFT. An in-flight operation is discarded and Y/Bout are not updated with partial results.
- IDLE: start=1 latches A and B into shift registers, clears borrow, sets counter=0, goes to SHIFT.
- SHIFT, each cycle i = 0..WIDTH-1:
  - a = areg[0], b = breg[0].
  - d = a ^ b ^ bor.
  - bor_next = (~a & b) | (~(a ^ b) & bor).
  - d is shifted MSB-first into the result register. Operand registers shift right.
  - Counter increments.
  - After the cycle with counter == WIDTH-1: next state DONE, and Y <= assembled result, Bout <= bor_next, on that same edge.
- DONE: done=1 for exactly one cycle.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operations, no dead cycle).
  - Otherwise the block returns to IDLE.
- start while in SHIFT is ignored. A/B changes during SHIFT have no effect.
- Latency: start accepted at edge 0, busy high for edges 1..WIDTH, done high in the cycle after edge WIDTH.
  - Throughput: one result per WIDTH+1 cycles.
- Y and Bout hold their values from the last completed operation until the next completion or reset.
- Arithmetic: purely unsigned mod 2^WIDTH. No sign extension.
- Boundary cases:
  - A == B gives Y=0, Bout=0.
  - B=0 gives Y=A, Bout=0.
  - A=0, B=1 gives Y=all ones, Bout=1.

Optional Feature:
- Macro: SERIAL_BORROW_SUBTRACTOR_OVF_EN.
- When defined:
  - Adds output port OVF (1 bit). OVF updates on the same edge as Y, resets to 0 and holds like Y.
  - OVF = two's-complement signed overflow of A - B = (A[MSB] ^ B[MSB]) & (A[MSB] ^ Y[MSB]), using the captured operands.
- When undefined:
  - Port OVF and all related logic are absent.
  - All other behaviour is identical.

Test Plan:
- rst held 2 cycles, then start with A=4'b0111, B=4'b0010 -> done pulses exactly 5 cycles after the start edge, Y=4'b0101, Bout=0; busy high 4 cycles.
- A=4'b0010, B=4'b0111 -> Y=4'b1011, Bout=1. Then A=4'b0000, B=4'b0001 -> Y=4'b1111, Bout=1. Then A=4'b1111, B=4'b1111 -> Y=4'b0000, Bout=0.
- Start with A=4'b1100, B=4'b0001; pulse start again and change A/B to 4'b0000 mid-SHIFT -> second start ignored, Y=4'b1011, Bout=0.
- Back-to-back: start asserted in the done cycle with A=4'b1001, B=4'b0111 -> accepted with no idle gap, Y=4'b0010, Bout=0, 5 cycles later.
- Start A=4'b1010, B=4'b0011; assert rst at SHIFT cycle 2 -> next cycle Y=0, Bout=0, busy=0, no done pulse. A fresh start then works normally.
- SERIAL_BORROW_SUBTRACTOR_OVF_EN defined:
  - A=4'b1000, B=4'b0001 -> Y=4'b0111, OVF=1.
  - A=4'b0111, B=4'b1111 -> Y=4'b1000, OVF=1.
  - A=4'b0101, B=4'b0011 -> Y=4'b0010, OVF=0.
